// File: rtl/althea_led_arbiter_if.sv
// Requester-side bundle for the LED arbiter: request/pattern in, grant/led/busy out.
// state_dbg mirrors the arbiter FSM state (0 = IDLE, 1 = OWNED) for observation.
interface althea_led_arbiter_if #(
  parameter int NUM_REQUESTERS = 4
);
  logic [NUM_REQUESTERS-1:0]   request;
  logic [8*NUM_REQUESTERS-1:0] pattern;
  logic [NUM_REQUESTERS-1:0]   grant;
  logic [7:0]                  led;
  logic                        busy;
  logic                        state_dbg;

  modport master (
    output request, pattern,
    input  grant, led, busy, state_dbg
  );

  modport slave (
    input  request, pattern,
    output grant, led, busy, state_dbg
  );
endinterface

// File: rtl/althea_led_arbiter.sv
// Time-slicing round-robin arbiter sharing the 8-LED bank between requesters.
// Handshake: request is a level; grant is one-hot owner (or zero), led follows the owner's pattern one cycle later.
module althea_led_arbiter #(
  parameter int         NUM_REQUESTERS = 4,
  parameter int         HOLD_CYCLES    = 50000000,
  parameter logic [7:0] IDLE_PATTERN   = 8'h00
) (
  input logic                 clock,
  input logic                 reset,
  althea_led_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQUESTERS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    led_q, led_d;

  logic [IW-1:0] pick_idx;
  logic [IW-1:0] cand;
  logic          pick_found;
  logic [NUM_REQUESTERS-1:0] grant;

  // Scan offsets from farthest to nearest so the nearest hit after last wins;
  // offset NUM_REQUESTERS lands on last itself and is considered least favoured.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NUM_REQUESTERS; i >= 1; i--) begin
      cand = IW'((int'(last_q) + i) % NUM_REQUESTERS);
      if (bus.request[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_OWNED;
          owner_d = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_OWNED: begin
        // Release and expiry share the same re-pick; on expiry the owner is
        // still requesting, so the pick always succeeds (possibly itself).
        if (!bus.request[owner_q] || (cnt_q == CNT_MAX)) begin
          cnt_d = '0;
          if (pick_found) begin
            owner_d = pick_idx;
            last_d  = pick_idx;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    led_d = (state_d == ST_OWNED) ? bus.pattern[{owner_d, 3'b000} +: 8] : IDLE_PATTERN;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      led_q   <= IDLE_PATTERN;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
    end
  end

  assign grant         = (state_q == ST_OWNED) ? (NUM_REQUESTERS'(1) << owner_q) : '0;
  assign bus.grant     = grant;
  assign bus.busy      = |grant;
  assign bus.led       = led_q;
  assign bus.state_dbg = state_q;
endmodule
